// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready output; define UART_RX_MAJORITY_EN for 3-sample majority voting
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_RATE  = 115200,
  parameter int CLK_FREQ   = 100_000_000
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i,
  output logic                  frame_err_o,
  output logic                  overrun_o
);
  localparam int PULSE_WIDTH      = CLK_FREQ / BAUD_RATE;
  localparam int HALF_PULSE_WIDTH = PULSE_WIDTH / 2;
  localparam int CW               = $clog2(PULSE_WIDTH) + 1;
  localparam int BW               = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LD_HALF  = CW'(HALF_PULSE_WIDTH);
  localparam logic [CW-1:0] LD_FULL  = CW'(PULSE_WIDTH - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
  state_t                r_state, w_state_nxt;
  logic [1:0]            r_sync;
  logic [CW-1:0]         r_clk_cnt, w_clk_cnt_nxt;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
  logic                  w_rx_s, w_bit, w_tick, w_deliver, w_ferr, w_consume;
  assign w_rx_s    = r_sync[1];
  assign w_tick    = (r_clk_cnt == '0);
  assign w_consume = valid_o & ready_i;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] r_vote;
  // capture the synchronised line two and one cycles before each sample point
  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_vote <= 2'b11;
    else if (r_clk_cnt == CW'(2)) r_vote[1] <= w_rx_s;
    else if (r_clk_cnt == CW'(1)) r_vote[0] <= w_rx_s;
  end
  assign w_bit = (r_vote[1] & r_vote[0]) | (r_vote[1] & w_rx_s) | (r_vote[0] & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif
  // frame recovery: next state, bit timing and data shifting
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = (r_clk_cnt != '0) ? r_clk_cnt - 1'b1 : '0;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_deliver     = 1'b0;
    w_ferr        = 1'b0;
    case (r_state)
      S_IDLE: if (!w_rx_s) begin
        w_state_nxt   = S_START;
        w_clk_cnt_nxt = LD_HALF;
      end
      S_START: if (w_tick) begin
        w_state_nxt   = w_bit ? S_IDLE : S_DATA;
        w_bit_cnt_nxt = '0;
        w_clk_cnt_nxt = w_bit ? '0 : LD_FULL;
      end
      S_DATA: if (w_tick) begin
        w_shift_nxt   = DATA_WIDTH'({w_bit, r_shift} >> 1);
        w_clk_cnt_nxt = LD_FULL;
        w_state_nxt   = (r_bit_cnt == LAST_BIT) ? S_STOP : S_DATA;
        w_bit_cnt_nxt = (r_bit_cnt == LAST_BIT) ? r_bit_cnt : r_bit_cnt + 1'b1;
      end
      S_STOP: if (w_tick) begin
        w_state_nxt = w_bit ? S_IDLE : S_BRK;
        w_deliver   = w_bit;
        w_ferr      = ~w_bit;
      end
      S_BRK: if (w_rx_s) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // synchroniser, state and counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_sync    <= 2'b11;
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      r_sync    <= {r_sync[0], rx_i};
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
    end
  end
  // output slot: delivery, consumption and one-cycle error pulses
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_o     <= 1'b0;
      data_o      <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= w_ferr;
      overrun_o   <= w_deliver & valid_o & ~ready_i;
      if (w_deliver && (!valid_o || ready_i)) begin
        data_o  <= r_shift;
        valid_o <= 1'b1;
      end else if (w_consume) begin
        valid_o <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed stimulus against a timestamp-based receiver model plus literal expectations
module tb_uart_rx;
  localparam int DW   = 8;
  localparam int PW   = 16;
  localparam int HALF = PW / 2;
  logic       clk_i = 1'b0, rst_ni = 1'b0, rx_i = 1'b1, ready_i = 1'b0;
  logic       valid_o, frame_err_o, overrun_o;
  logic [7:0] data_o;
  int         total = 0, passed = 0, cyc = 0;
  uart_rx #(.DATA_WIDTH(DW), .BAUD_RATE(1), .CLK_FREQ(PW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i), .valid_o(valid_o), .data_o(data_o),
    .ready_i(ready_i), .frame_err_o(frame_err_o), .overrun_o(overrun_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  // model: absolute sample times derived from the line edge seen through two flops
  logic [1:0] m_sync = 2'b11;
  logic [2:0] m_hist = 3'b111;
  int         m_mode = 0, m_next = 0, m_bit = 0;
  logic [7:0] m_shift = '0, m_data = '0;
  logic       m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0;
  always @(posedge clk_i) begin : model
    logic rs, smp;
    cyc++;
    rs     = m_sync[1];
    m_sync = {m_sync[0], rx_i};
    m_hist = {m_hist[1:0], rs};
`ifdef UART_RX_MAJORITY_EN
    smp = (int'(m_hist[2]) + int'(m_hist[1]) + int'(m_hist[0])) >= 2;
`else
    smp = rs;
`endif
    if (!rst_ni) begin
      m_sync = 2'b11; m_hist = 3'b111; m_mode = 0;
      m_valid = 1'b0; m_data = '0; m_fe = 1'b0; m_ov = 1'b0;
    end else begin
      m_fe = 1'b0;
      m_ov = 1'b0;
      if (m_valid && ready_i) m_valid = 1'b0;
      if (m_mode == 0) begin
        if (!rs) begin m_mode = 1; m_next = cyc + HALF + 1; m_bit = -1; end
      end else if (m_mode == 2) begin
        if (rs) m_mode = 0;
      end else if (cyc == m_next) begin
        if (m_bit < 0) begin
          if (smp) m_mode = 0;
          else begin m_bit = 0; m_next += PW; end
        end else if (m_bit < DW) begin
          m_shift[m_bit] = smp; m_bit++; m_next += PW;
        end else begin
          m_mode = smp ? 0 : 2;
          m_fe   = ~smp;
          if (smp && m_valid) m_ov = 1'b1;
          else if (smp) begin m_valid = 1'b1; m_data = m_shift; end
        end
      end
    end
  end
  // per-cycle compare and event monitor
  int   vc = 0, fec = 0, ovc = 0, first_rise = -1;
  logic prev_v = 1'b0;
  logic [7:0] last_data = '0;
  always @(negedge clk_i) begin
    chk("outputs", 32'({valid_o, data_o, frame_err_o, overrun_o}), 32'({m_valid, m_data, m_fe, m_ov}));
    if (valid_o === 1'b1) begin vc++; last_data = data_o; end
    if (valid_o === 1'b1 && !prev_v) first_rise = cyc;
    prev_v = (valid_o === 1'b1);
    if (frame_err_o === 1'b1) fec++;
    if (overrun_o === 1'b1) ovc++;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic send_bit(input logic b, input int g);
    for (int i = 0; i < PW; i++) begin
      rx_i = (i == g) ? ~b : b;
      tick(1);
    end
  endtask
  task automatic send(input logic [7:0] d, input logic stop, input int g);
    send_bit(1'b0, -1);
    for (int i = 0; i < DW; i++) send_bit(d[i], g);
    send_bit(stop, -1);
  endtask
  int t0, v0, f0, o0;
  logic [7:0] exp_g;
  initial begin
    tick(3);
    chk("reset_outputs", 32'({valid_o, data_o, frame_err_o, overrun_o}), 32'd0);
    rst_ni = 1'b1;
    tick(200);
    chk("idle_valid", vc, 0);
    chk("idle_ferr", fec, 0);
    chk("idle_ovr", ovc, 0);
    ready_i = 1'b1;
    t0 = cyc; v0 = vc;
    send(8'hA5, 1'b1, -1);
    tick(20);
    chk("a5_latency", first_rise - t0, 156);
    chk("a5_valid_cycles", vc - v0, 1);
    chk("a5_data", last_data, 8'hA5);
    v0 = vc; f0 = fec;
    rx_i = 1'b0; tick(4); rx_i = 1'b1; tick(30);
    chk("glitch_valid", vc - v0, 0);
    chk("glitch_ferr", fec - f0, 0);
    send(8'h3C, 1'b1, -1);
    tick(20);
    chk("3c_data", last_data, 8'h3C);
    chk("3c_valid_cycles", vc - v0, 1);
    v0 = vc; f0 = fec;
    send(8'h55, 1'b0, -1);
    tick(100);
    chk("brk_ferr", fec - f0, 1);
    chk("brk_valid", vc - v0, 0);
    rx_i = 1'b1; tick(20);
    send(8'h0F, 1'b1, -1);
    tick(20);
    chk("0f_data", last_data, 8'h0F);
    chk("brk_ferr_total", fec - f0, 1);
    ready_i = 1'b0; o0 = ovc;
    send(8'h11, 1'b1, -1);
    send(8'h22, 1'b1, -1);
    tick(20);
    chk("ovr_pulses", ovc - o0, 1);
    chk("ovr_data", data_o, 8'h11);
    chk("ovr_valid", valid_o, 1'b1);
    ready_i = 1'b1;
    tick(2);
    chk("ovr_consumed", valid_o, 1'b0);
`ifdef UART_RX_MAJORITY_EN
    exp_g = 8'hC3;
`else
    exp_g = 8'h3C;
`endif
    v0 = vc;
    send(8'hC3, 1'b1, 9);
    tick(20);
    chk("glitchy_c3_data", last_data, exp_g);
    chk("glitchy_c3_valid", vc - v0, 1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Asynchronous serial receiver: 8N1-style framing, LSB first, line idle high. It sits between the board RX pin and the on-chip consumer, as the partner of the existing UART transmitter. It oversamples the line with the system clock, recovers each frame by mid-bit sampling and presents it on a valid/ready output handshake. Framing errors and overruns are reported as single-cycle pulses.

Parameters:
DATA_WIDTH, 8, data bits per frame
BAUD_RATE, 115200, line bit rate in bit/s
CLK_FREQ, 100_000_000, clk_i frequency in Hz
Derived values:
- PULSE_WIDTH = CLK_FREQ / BAUD_RATE (integer division)
- HALF_PULSE_WIDTH = PULSE_WIDTH / 2
- PULSE_WIDTH >= 4 required

Ports:
clk_i  input  1  system clock
rst_ni  input  1  reset; synchronous, active-low, single clock domain
rx_i  input  1  serial line, asynchronous to clk_i
valid_o  output  1  data_o holds an unconsumed frame
data_o  output  DATA_WIDTH  received data, bit 0 = first data bit on the line
ready_i  input  1  consumer accepts data_o when valid_o && ready_i
frame_err_o  output  1  1-cycle pulse: stop bit sampled low
overrun_o  output  1  1-cycle pulse: a frame completed while the previous frame was still pending

Behaviour:
- Reset values (rst_ni low at posedge):
  - valid_o=0, data_o=0, frame_err_o=0, overrun_o=0
  - synchroniser flops=1, state=IDLE, all counters=0
- rx_i passes through a 2-flop synchroniser, giving rx_s. All decisions use rx_s.
- Counter rule: a count loaded with N acts on the (N+1)th following cycle, when it reaches 0. Counter width is $clog2(PULSE_WIDTH)+1.
- IDLE:
  - rx_s==0 -> START, clk_cnt<=HALF_PULSE_WIDTH.
- START:
  - Count down to 0, then sample rx_s.
  - Sample 0 -> DATA, bit_cnt<=0, clk_cnt<=PULSE_WIDTH-1.
  - Sample 1 -> IDLE (glitch rejected; no flag raised).
- DATA:
  - Count down to 0, then shift_r[bit_cnt]<=rx_s and clk_cnt<=PULSE_WIDTH-1.
  - After bit DATA_WIDTH-1 -> STOP; otherwise bit_cnt+1.
- STOP:
  - Count down to 0, then sample rx_s.
  - Sample 1 -> deliver the frame, go to IDLE.
  - Sample 0 -> frame_err_o=1 on the next cycle, frame discarded, go to BRK.
- BRK:
  - Wait for rx_s==1, then go to IDLE. Long breaks therefore produce exactly one frame_err pulse.
- Sample spacing: the start-bit sample is HALF_PULSE_WIDTH+1 cycles after the falling edge is seen on rx_s. Every later sample follows the previous one by exactly PULSE_WIDTH cycles.
- Deliver (registered, visible the cycle after the stop sample):
  - Pending slot free, or freed this cycle (valid_o && ready_i): data_o<=shift_r, valid_o<=1. No overrun.
  - Pending and not consumed this cycle: new frame dropped, data_o unchanged, overrun_o pulses 1 cycle.
- Output handshake:
  - valid_o falls the cycle after valid_o && ready_i, unless a delivery happens in the same cycle.
  - data_o is stable while valid_o=1 && !ready_i.
  - ready_i is ignored while valid_o=0.
- Reset mid-frame: the partial frame is discarded and the block returns to IDLE. A line still low after reset is treated as a new start bit.
- The receiver returns to IDLE at mid-stop-bit, so back-to-back frames with no idle gap are received.
- Illegal state encoding -> IDLE.

Optional Feature:
Macro: UART_RX_MAJORITY_EN
- Defined: every sample point (start, data, stop) uses the majority of rx_s taken at clk_cnt==2, 1 and 0. Sample timing is otherwise unchanged.
- Undefined: a single sample at clk_cnt==0.
- Port list is identical in both builds.

Test Plan:
All scenarios use CLK_FREQ=16, BAUD_RATE=1 (PULSE_WIDTH=16, HALF_PULSE_WIDTH=8) and DATA_WIDTH=8.
1. Reset held 3 cycles with rx_i=1 -> all outputs 0, then no activity for 200 cycles.
2. Send 0xA5 framed at 16 cycles/bit, ready_i=1 -> valid_o for exactly 1 cycle with data_o=0xA5. valid_o rises 2(sync)+9+8*16+16+1 cycles after the rx_i falling edge.
3. rx_i low for 4 cycles, then high -> START rejects it, valid_o and frame_err_o stay 0. A following 0x3C frame is received correctly.
4. Send 0x55 with the stop bit low, then hold the line low for 100 cycles -> exactly one frame_err_o pulse, no valid_o. Then rx_i=1 and send 0x0F -> data_o=0x0F.
5. ready_i=0, send 0x11 then 0x22 back-to-back -> data_o stays 0x11 and overrun_o pulses once. Raise ready_i -> 0x11 consumed, valid_o falls.
6. With UART_RX_MAJORITY_EN defined: send 0xC3 with a 1-cycle inverted glitch at every bit centre -> data_o=0xC3. Without the macro, at least one bit is corrupted.
